// File: rtl/reorder_buffer_if.sv
// Issue / CDB / retire / operand-lookup bundle between the core and the reorder buffer.
// master = core side (issue, CDB, lookups); slave = the reorder buffer itself.
interface reorder_buffer_if #(
  parameter int ID_W  = 4,
  parameter int REG_W = 4
);
  logic             alloc_req;
  logic [REG_W-1:0] alloc_dest;
  logic             alloc_ready;
  logic [ID_W-1:0]  alloc_id;

  logic             load_rob;
  logic [ID_W-1:0]  rob_in;
  logic [REG_W-1:0] dest_rob;

  logic             cdb_valid;
  logic [ID_W-1:0]  cdb_id;
  logic [15:0]      cdb_value;
  logic             cdb_mispredict;

  logic             load_value;
  logic [15:0]      value_in;
  logic [REG_W-1:0] dest_value;
  logic             commit_valid;
  logic             flush;

  logic [ID_W-1:0]  rd_id_a;
  logic [ID_W-1:0]  rd_id_b;
  logic             rd_ready_a;
  logic             rd_ready_b;
  logic [15:0]      rd_value_a;
  logic [15:0]      rd_value_b;

  // Handshake: an entry is allocated on a clock edge iff alloc_req & alloc_ready
  // were both high in the preceding cycle; alloc_id is the tag handed out.
  modport master (
    output alloc_req, alloc_dest, cdb_valid, cdb_id, cdb_value, cdb_mispredict,
           rd_id_a, rd_id_b,
    input  alloc_ready, alloc_id, load_rob, rob_in, dest_rob, load_value, value_in,
           dest_value, commit_valid, flush, rd_ready_a, rd_ready_b, rd_value_a, rd_value_b
  );

  modport slave (
    input  alloc_req, alloc_dest, cdb_valid, cdb_id, cdb_value, cdb_mispredict,
           rd_id_a, rd_id_b,
    output alloc_ready, alloc_id, load_rob, rob_in, dest_rob, load_value, value_in,
           dest_value, commit_valid, flush, rd_ready_a, rd_ready_b, rd_value_a, rd_value_b
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer: allocates tags at issue, captures CDB results,
// retires one entry per cycle in program order and flushes on a mispredicted branch.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int ID_W   = 4,
  parameter int REG_W  = 4,
  parameter int PC_REG = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  reorder_buffer_if.slave  rob
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   head_q;
  logic [PTR_W:0]   tail_q;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] mis_q;
  logic [REG_W-1:0] dest_q  [DEPTH];
  logic [15:0]      value_q [DEPTH];

  logic [PTR_W-1:0] head_idx;
  logic [PTR_W-1:0] tail_idx;
  logic [PTR_W-1:0] cdb_idx;
  logic             full;
  logic             empty;
  logic             alloc_fire;
  logic             cdb_hit;
  logic             commit;
  logic             flush_now;

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];
  assign cdb_idx  = rob.cdb_id[PTR_W-1:0];

  assign full  = (head_q[PTR_W] != tail_q[PTR_W]) && (head_idx == tail_idx);
  assign empty = (head_q == tail_q);

  // Allocation: no bypass from a same-cycle retire when full.
  assign rob.alloc_ready = !full && !flush_now;
  assign rob.alloc_id    = ID_W'(tail_idx);
  assign alloc_fire      = rob.alloc_req && rob.alloc_ready;

  // Rename port is combinational so the regfile latches the tag on the allocating edge.
  assign rob.load_rob = alloc_fire && (rob.alloc_dest != REG_W'(PC_REG));
  assign rob.rob_in   = rob.alloc_id;
  assign rob.dest_rob = rob.alloc_dest;

  // Invalid (all-ones) and out-of-range tags both fail the range test.
  assign cdb_hit = rob.cdb_valid && (rob.cdb_id < ID_W'(DEPTH)) && valid_q[cdb_idx];

  // Retire reads registered done bits only, so a CDB write is retirable one cycle later.
  assign commit    = !empty && valid_q[head_idx] && done_q[head_idx];
  assign flush_now = commit && mis_q[head_idx];

  assign rob.commit_valid = commit;
  assign rob.flush        = flush_now;
  assign rob.load_value   = commit && !mis_q[head_idx] && (dest_q[head_idx] != REG_W'(PC_REG));
  assign rob.value_in     = commit ? value_q[head_idx] : 16'h0000;
  assign rob.dest_value   = commit ? dest_q[head_idx]  : '0;

  // Operand lookup with same-cycle CDB bypass, for both read ports.
  logic [ID_W-1:0] rd_id  [2];
  logic [1:0]      rd_rdy;
  logic [15:0]     rd_val [2];

  always_comb begin
    rd_id[0] = rob.rd_id_a;
    rd_id[1] = rob.rd_id_b;
    rd_rdy   = 2'b00;
    rd_val[0] = 16'h0000;
    rd_val[1] = 16'h0000;
    for (int p = 0; p < 2; p++) begin
      if ((rd_id[p] < ID_W'(DEPTH)) && valid_q[rd_id[p][PTR_W-1:0]]) begin
        if (rob.cdb_valid && (rob.cdb_id == rd_id[p])) begin
          rd_rdy[p] = 1'b1;
          rd_val[p] = rob.cdb_value;
        end else begin
          rd_rdy[p] = done_q[rd_id[p][PTR_W-1:0]];
          rd_val[p] = value_q[rd_id[p][PTR_W-1:0]];
        end
      end
    end
  end

  assign rob.rd_ready_a = rd_rdy[0];
  assign rob.rd_ready_b = rd_rdy[1];
  assign rob.rd_value_a = rd_val[0];
  assign rob.rd_value_b = rd_val[1];

  // A flush overrides any allocation or CDB write on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      mis_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i]  <= '0;
        value_q[i] <= 16'h0000;
      end
    end else if (flush_now) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      mis_q   <= '0;
    end else begin
      if (alloc_fire) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        mis_q[tail_idx]   <= 1'b0;
        dest_q[tail_idx]  <= rob.alloc_dest;
        value_q[tail_idx] <= 16'h0000;
        tail_q            <= tail_q + PTR_ONE;
      end
      if (cdb_hit) begin
        done_q[cdb_idx]  <= 1'b1;
        mis_q[cdb_idx]   <= rob.cdb_mispredict;
        value_q[cdb_idx] <= rob.cdb_value;
      end
      if (commit) begin
        valid_q[head_idx] <= 1'b0;
        done_q[head_idx]  <= 1'b0;
        head_q            <= head_q + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: a program-order queue model predicts every cycle's
// outputs; a negedge monitor pops predictions and retire records and compares.
module tb_reorder_buffer;
  localparam int DEPTH  = 8;
  localparam int ID_W   = 4;
  localparam int REG_W  = 4;
  localparam int PC_REG = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if #(.ID_W(ID_W), .REG_W(REG_W)) rob_bus ();

  reorder_buffer #(.DEPTH(DEPTH), .ID_W(ID_W), .REG_W(REG_W), .PC_REG(PC_REG)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rob     (rob_bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         tag;
    logic [3:0] dest;
    logic [15:0] val;
    bit         mis;
    bit         done;
  } ent_t;

  typedef struct {
    logic        commit, flush, ready, load_rob;
    logic [3:0]  id, dest;
    logic        rdy_a, chk_a, rdy_b, chk_b;
    logic [15:0] val_a, val_b;
  } cyc_t;

  ent_t        m_q[$];
  int          m_tail = 0;
  cyc_t        cyc_q[$];
  logic [21:0] exp_q[$];   // {dest, value, load_value, mispredict} in program order

  function automatic int find(input int tag);
    foreach (m_q[i]) if (m_q[i].tag == tag) return i;
    return -1;
  endfunction

  function automatic void predict_rd(input int id, input bit cv, input int ctag,
                                     input logic [15:0] cval, output logic rdy,
                                     output logic chk, output logic [15:0] val);
    int k;
    k = (id < DEPTH) ? find(id) : -1;
    if (k < 0) begin
      rdy = 1'b0; chk = (id >= DEPTH); val = 16'h0000;
    end else if (cv && ctag == id) begin
      rdy = 1'b1; chk = 1'b1; val = cval;
    end else if (m_q[k].done) begin
      rdy = 1'b1; chk = 1'b1; val = m_q[k].val;
    end else begin
      rdy = 1'b0; chk = 1'b0; val = 16'h0000;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic drive_idle();
    rob_bus.alloc_req = 1'b0;      rob_bus.alloc_dest = '0;
    rob_bus.cdb_valid = 1'b0;      rob_bus.cdb_id = '0;
    rob_bus.cdb_value = 16'h0000;  rob_bus.cdb_mispredict = 1'b0;
    rob_bus.rd_id_a = '0;          rob_bus.rd_id_b = '0;
  endtask

  // One clock cycle: drive inputs, predict outputs, advance the model past the edge.
  task automatic step(input bit areq, input logic [3:0] adest, input logic [15:0] aval,
                      input bit amis, input bit cv, input int ctag, input int ra, input int rb);
    int k;
    logic [15:0] cval;
    bit cmis, commit, fl, acc;
    cyc_t c;
    k    = cv ? find(ctag) : -1;
    cval = (k >= 0) ? m_q[k].val : 16'($urandom);
    cmis = (k >= 0) ? m_q[k].mis : 1'($urandom_range(0, 1));
    rob_bus.alloc_req = areq;  rob_bus.alloc_dest = adest;
    rob_bus.cdb_valid = cv;    rob_bus.cdb_id = ID_W'(ctag);
    rob_bus.cdb_value = cval;  rob_bus.cdb_mispredict = cmis;
    rob_bus.rd_id_a = ID_W'(ra); rob_bus.rd_id_b = ID_W'(rb);

    commit = (m_q.size() > 0) && m_q[0].done;
    fl     = commit && m_q[0].mis;
    acc    = areq && (m_q.size() < DEPTH) && !fl;
    c.commit   = commit;
    c.flush    = fl;
    c.ready    = (m_q.size() < DEPTH) && !fl;
    c.id       = 4'(m_tail);
    c.load_rob = acc && (adest != PC_REG);
    c.dest     = adest;
    predict_rd(ra, cv, ctag, cval, c.rdy_a, c.chk_a, c.val_a);
    predict_rd(rb, cv, ctag, cval, c.rdy_b, c.chk_b, c.val_b);
    cyc_q.push_back(c);
    if (acc) exp_q.push_back({adest, aval, (adest != PC_REG) && !amis, amis});

    if (fl) begin
      m_q.delete();
      m_tail = 0;
    end else begin
      if (k >= 0) m_q[k].done = 1'b1;
      if (commit) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back('{tag: m_tail, dest: adest, val: aval, mis: amis, done: 1'b0});
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 16'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alloc_ready"}, rob_bus.alloc_ready, 1);
    check({tag, "_alloc_id"}, rob_bus.alloc_id, 0);
    check({tag, "_load_rob"}, rob_bus.load_rob, 0);
    check({tag, "_load_value"}, rob_bus.load_value, 0);
    check({tag, "_commit_valid"}, rob_bus.commit_valid, 0);
    check({tag, "_flush"}, rob_bus.flush, 0);
    check({tag, "_rd_ready_a"}, rob_bus.rd_ready_a, 0);
    check({tag, "_value_in"}, rob_bus.value_in, 0);
    check({tag, "_dest_value"}, rob_bus.dest_value, 0);
    check({tag, "_rd_value_a"}, rob_bus.rd_value_a, 0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    drive_idle();
    #1;
    check_reset_outputs(tag);
    m_q.delete();
    m_tail = 0;
    exp_q.delete();
    cyc_q.delete();
    @(negedge clk); @(negedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    cyc_t c;
    logic [21:0] r;
    if (reset_n && cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      check("commit_valid", rob_bus.commit_valid, c.commit);
      check("flush", rob_bus.flush, c.flush);
      check("alloc_ready", rob_bus.alloc_ready, c.ready);
      check("alloc_id", rob_bus.alloc_id, c.id);
      check("rob_in", rob_bus.rob_in, c.id);
      check("load_rob", rob_bus.load_rob, c.load_rob);
      check("dest_rob", rob_bus.dest_rob, c.dest);
      check("rd_ready_a", rob_bus.rd_ready_a, c.rdy_a);
      check("rd_ready_b", rob_bus.rd_ready_b, c.rdy_b);
      if (c.chk_a) check("rd_value_a", rob_bus.rd_value_a, c.val_a);
      if (c.chk_b) check("rd_value_b", rob_bus.rd_value_b, c.val_b);
      if (c.commit) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL retire_queue: got no expected record for a predicted retire at %0t", $time);
        end else begin
          r = exp_q.pop_front();
          check("dest_value", rob_bus.dest_value, r[21:18]);
          check("value_in", rob_bus.value_in, r[17:2]);
          check("load_value", rob_bus.load_value, r[1]);
          if (r[0]) exp_q.delete();
        end
      end else begin
        check("load_value_idle", rob_bus.load_value, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int nd[$];
    bit areq, amis, cv;
    logic [3:0] adest;
    int ctag, ra, rb, t, sel;

    drive_idle();
    #2;
    check_reset_outputs("por");
    #20 reset_n = 1'b1;
    @(posedge clk); #1;

    // Fill from empty: tags 0..7, then refusal while full.
    for (int i = 0; i < DEPTH + 1; i++) step(1, 4'd3, 16'($urandom), 0, 0, 0, 0, 0);

    // Out-of-order completion, in-order retire.
    do_reset("rst1");
    step(1, 4'd1, 16'h3333, 0, 0, 0, 0, 0);
    step(1, 4'd2, 16'h2222, 0, 0, 0, 0, 0);
    step(1, 4'd3, 16'h1111, 0, 0, 0, 0, 0);
    step(0, 4'd0, 16'h0, 0, 1, 2, 2, 1);
    step(0, 4'd0, 16'h0, 0, 1, 1, 2, 1);
    step(0, 4'd0, 16'h0, 0, 1, 0, 0, 15);
    idle_steps(4);

    // Entry with no GPR destination retires without a register write.
    step(1, 4'(PC_REG), 16'h5a5a, 0, 0, 0, 0, 0);
    step(0, 4'd0, 16'h0, 0, 1, 3, 3, 9);
    idle_steps(2);

    // Mispredicted branch with younger entries and allocation held high.
    do_reset("rst2");
    step(1, 4'd3, 16'h0a0a, 0, 0, 0, 0, 0);
    step(1, 4'(PC_REG), 16'h0b0b, 1, 0, 0, 0, 0);
    step(1, 4'd1, 16'h0c0c, 0, 0, 0, 0, 0);
    step(1, 4'd2, 16'h0d0d, 0, 0, 0, 0, 0);
    step(1, 4'd3, 16'h0e0e, 0, 0, 0, 0, 0);
    step(1, 4'd5, 16'h1001, 0, 1, 1, 3, 1);
    step(1, 4'd5, 16'h1002, 0, 1, 0, 3, 0);
    for (int i = 0; i < 4; i++) step(1, 4'd5, 16'(16'h2000 + i), 0, 0, 0, 3, 1);
    idle_steps(2);

    // Wrap and full: retire and allocate in the same cycle is refused while full.
    do_reset("rst3");
    for (int i = 0; i < DEPTH; i++) step(1, 4'(i), 16'(16'h4000 + i), 0, 0, 0, 0, 0);
    step(1, 4'd6, 16'h4100, 0, 1, 0, 0, 0);
    step(1, 4'd6, 16'h4101, 0, 0, 0, 0, 0);
    step(1, 4'd6, 16'h4102, 0, 0, 0, 0, 0);
    step(1, 4'd6, 16'h4103, 0, 0, 0, 0, 0);

    // Same-cycle CDB bypass on the lookup ports.
    do_reset("rst4");
    step(1, 4'd1, 16'h1234, 0, 0, 0, 0, 0);
    step(1, 4'd2, 16'h5678, 0, 0, 0, 0, 0);
    step(1, 4'd3, 16'hBEEF, 0, 0, 0, 0, 0);
    step(0, 4'd0, 16'h0, 0, 1, 2, 2, 15);
    step(0, 4'd0, 16'h0, 0, 1, 15, 2, 12);

    // Reset while the head is retiring.
    do_reset("rst5");
    step(1, 4'd4, 16'h7777, 0, 0, 0, 0, 0);
    step(1, 4'd5, 16'h8888, 0, 0, 0, 0, 0);
    step(0, 4'd0, 16'h0, 0, 1, 0, 0, 0);
    check("pre_reset_load_value", rob_bus.load_value, 1);
    check("pre_reset_commit", rob_bus.commit_valid, 1);
    do_reset("mid");
    step(1, 4'd2, 16'h9999, 0, 0, 0, 0, 1);

    // Randomised traffic.
    do_reset("rst6");
    for (int n = 0; n < 1500; n++) begin
      areq  = ($urandom_range(0, 9) < 7);
      adest = 4'($urandom_range(0, 8));
      amis  = ($urandom_range(0, 19) == 0);
      nd.delete();
      foreach (m_q[i]) if (!m_q[i].done) nd.push_back(m_q[i].tag);
      sel = $urandom_range(0, 9);
      cv = 1'b0; ctag = 0;
      if (sel < 6 && nd.size() > 0) begin
        cv = 1'b1; ctag = nd[$urandom_range(0, nd.size() - 1)];
      end else if (sel == 6) begin
        cv = 1'b1; ctag = $urandom_range(8, 15);
      end else if (sel == 7) begin
        t = $urandom_range(0, DEPTH - 1);
        if (find(t) < 0) begin cv = 1'b1; ctag = t; end
      end
      ra = $urandom_range(0, 15);
      rb = cv ? ctag : $urandom_range(0, DEPTH - 1);
      step(areq, adest, 16'($urandom), amis, cv, ctag, ra, rb);
    end

    // Drain everything still outstanding.
    for (int n = 0; n < 4 * DEPTH && m_q.size() > 0; n++) begin
      nd.delete();
      foreach (m_q[i]) if (!m_q[i].done) nd.push_back(m_q[i].tag);
      if (nd.size() > 0) step(0, 4'd0, 16'h0, 0, 1, nd[0], nd[0], 0);
      else step(0, 4'd0, 16'h0, 0, 0, 0, 0, 0);
    end
    idle_steps(2);
    check("drain_exp_q_empty", exp_q.size(), 0);
    check("drain_model_empty", m_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
